ascii_to_hid_report: RTL

Reverse of the keyboard path: converts a stream of ASCII characters into USB HID boot-keyboard report pairs (press, then all-keys-up) with programmable hold and gap times. It sits in the `clk50` domain. Its outputs drive a HID device endpoint, or loop back into the `R0`/`R2` inputs of `USB2ASCII` to exercise the terminal without a physical keyboard. Characters are buffered in an internal FIFO so a burst from a text source is typed out at keyboard pace.

---
 rtl/ascii_to_hid_report.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ascii_to_hid_report.sv
// ascii_to_hid_report: buffers ASCII characters and types each one as a HID press/release report pair
module ascii_to_hid_report #(
  parameter int unsigned HOLD_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES  = 500000,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       NewKey,
  input  logic [7:0] Ascii,
  output logic [7:0] Rmodifiers,
  output logic [7:0] R0,
  output logic       Report_Valid,
  output logic       Busy,
  output logic       Full,
  output logic       Overflow,
  output logic       Unmapped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0] ch_q, ch_d, mod_q, mod_d, r0_q, r0_d;
  logic pend_q, pend_d, rv_q, rv_d, unm_q, unm_d, ovf_q, ovf_d, busy_q, busy_d;
  logic push, pop;
  logic [9:0] map;
  function automatic logic [9:0] map_char(input logic [7:0] c);
    if (c >= "a" && c <= "z") return {2'b10, c - 8'h5d};
    if (c >= "A" && c <= "Z") return {2'b11, c - 8'h3d};
    if (c >= "1" && c <= "9") return {2'b10, c - 8'h13};
    case (c)
      "0":    return {2'b10, 8'h27};
      "!":    return {2'b11, 8'h1e};
      "@":    return {2'b11, 8'h1f};
      "#":    return {2'b11, 8'h20};
      "$":    return {2'b11, 8'h21};
      "%":    return {2'b11, 8'h22};
      "^":    return {2'b11, 8'h23};
      "&":    return {2'b11, 8'h24};
      "*":    return {2'b11, 8'h25};
      "(":    return {2'b11, 8'h26};
      ")":    return {2'b11, 8'h27};
      8'h0d:  return {2'b10, 8'h28};
      8'h1b:  return {2'b10, 8'h29};
      8'h08:  return {2'b10, 8'h2a};
      8'h09:  return {2'b10, 8'h2b};
      " ":    return {2'b10, 8'h2c};
      "-":    return {2'b10, 8'h2d};
      "=":    return {2'b10, 8'h2e};
      "[":    return {2'b10, 8'h2f};
      "]":    return {2'b10, 8'h30};
      "\\":   return {2'b10, 8'h31};
      ";":    return {2'b10, 8'h33};
      "'":    return {2'b10, 8'h34};
      8'h60:  return {2'b10, 8'h35};
      ",":    return {2'b10, 8'h36};
      ".":    return {2'b10, 8'h37};
      "/":    return {2'b10, 8'h38};
      "_":    return {2'b11, 8'h2d};
      "+":    return {2'b11, 8'h2e};
      "{":    return {2'b11, 8'h2f};
      "}":    return {2'b11, 8'h30};
      "|":    return {2'b11, 8'h31};
      ":":    return {2'b11, 8'h33};
      "\"":   return {2'b11, 8'h34};
      "~":    return {2'b11, 8'h35};
      "<":    return {2'b11, 8'h36};
      ">":    return {2'b11, 8'h37};
      "?":    return {2'b11, 8'h38};
      default: return 10'd0;
    endcase
  endfunction
  always_comb begin
    map = map_char(ch_q);
    push = NewKey && !Full;
    pop = state_q == IDLE && !pend_q && count_q != '0;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d = NewKey && Full;
    busy_d = state_q != IDLE || pend_q || count_q != '0;
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    ch_d = ch_q;
    mod_d = mod_q;
    r0_d = r0_q;
    rv_d = 1'b0;
    unm_d = 1'b0;
    case (state_q)
      HOLD: begin
        cnt_d = cnt_q == HOLD_CYCLES ? '0 : cnt_q + 1;
        state_d = cnt_q == HOLD_CYCLES ? GAP : HOLD;
        mod_d = cnt_q == HOLD_CYCLES ? 8'h00 : mod_q;
        r0_d = cnt_q == HOLD_CYCLES ? 8'h00 : r0_q;
        rv_d = cnt_q == HOLD_CYCLES;
      end
      GAP: begin
        cnt_d = cnt_q + 1;
        state_d = cnt_q == GAP_CYCLES - 1 ? IDLE : GAP;
      end
      default: begin
        if (pend_q) begin
          pend_d = 1'b0;
          unm_d = !map[9];
          rv_d = map[9];
          state_d = map[9] ? HOLD : IDLE;
          cnt_d = map[9] ? 32'd1 : cnt_q;
          mod_d = map[9] ? {6'b0, map[8], 1'b0} : mod_q;
          r0_d = map[9] ? map[7:0] : r0_q;
        end else if (pop) begin
          pend_d = 1'b1;
          ch_d = mem_q[rp_q];
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= Ascii;
    if (rst) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      ch_q <= '0;
      mod_q <= '0;
      r0_q <= '0;
      pend_q <= 1'b0;
      rv_q <= 1'b0;
      unm_q <= 1'b0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      mod_q <= mod_d;
      r0_q <= r0_d;
      pend_q <= pend_d;
      rv_q <= rv_d;
      unm_q <= unm_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
    end
  end
  assign Rmodifiers = mod_q;
  assign R0 = r0_q;
  assign Report_Valid = rv_q;
  assign Busy = busy_q;
  assign Full = count_q == FULL_CNT;
  assign Overflow = ovf_q;
  assign Unmapped = unm_q;
endmodule
